// File: rtl/fixlen_pkg.sv
// -----------------------------------------------------------------------------
// fixlen_pkg
// Shared types and width helpers for the fixed-length byte arbiter slice.
//   state_t           : arbiter grant state (IDLE / BURST)
//   clog2_min1()      : max(1, clog2(x)), used for index and counter widths
//   ch_width()        : width of a channel index for n requesters
//   cnt_width()       : width of the per-packet byte counter
//   bytes_per_packet(): symbols/packet x bytes/symbol
// Optional feature macro used by the slice: FIXLEN_ARB_STRICT_PRIO_EN
// -----------------------------------------------------------------------------
package fixlen_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int clog2_min1(input int x);
        int r;
        r = $clog2(x);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int ch_width(input int n_ch);
        return clog2_min1(n_ch);
    endfunction

    function automatic int cnt_width(input int bytes_pp);
        return clog2_min1(bytes_pp);
    endfunction

    function automatic int bytes_per_packet(input int sym_pp, input int bytes_ps);
        return sym_pp * bytes_ps;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational requester search. Round-robin by default: channels are scanned
// starting at (last + 1) mod N_CH, wrapping, and the first asserted one wins.
// With FIXLEN_ARB_STRICT_PRIO_EN defined the lowest-index asserted channel wins
// and 'last' is ignored.
// Ports:
//   req   in  N_CH   request vector
//   last  in  IDX_W  index of the previously served channel
//   found out 1      at least one request present
//   idx   out IDX_W  winning channel (0 when none)
// -----------------------------------------------------------------------------
module rr_picker
    import fixlen_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int IDX_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

`ifdef FIXLEN_ARB_STRICT_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;
`endif

    always_comb begin
        int              cand;
        logic [N_CH-1:0] shifted;
        found   = 1'b0;
        idx     = '0;
        cand    = 0;
        shifted = '0;
        for (int i = 0; i < N_CH; i++) begin
`ifdef FIXLEN_ARB_STRICT_PRIO_EN
            cand = i;
`else
            cand = (int'(last) + 1 + i) % N_CH;
`endif
            // Shift the candidate to bit 0 rather than indexing with a
            // run-time integer.
            shifted = req >> cand;
            if (!found && shifted[0]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fixlen_byte_arbiter.sv
// -----------------------------------------------------------------------------
// fixlen_byte_arbiter
// Shares one fixed-length packet assembler among N_CH byte streams. A grant is
// issued to one requester for exactly one packet (SYMBOL_PER_PACKET x
// BYTES_PER_SYMBOL bytes) and is never preempted; the granted stream is passed
// through combinationally with SOP/EOP markers and a channel tag.
// Optional macro: FIXLEN_ARB_STRICT_PRIO_EN (strict priority instead of
// round-robin, selected inside rr_picker).
// Ports:
//   clock_clk               in   clock
//   reset_reset             in   asynchronous, active-high reset
//   asi_in_data             in   N_CH x BITS_PER_BYTES requester bytes
//   asi_in_valid            in   per-requester valid
//   asi_in_ready            out  per-requester ready (only granted bit may be 1)
//   aso_out0_data           out  granted byte
//   aso_out0_valid          out  granted byte valid
//   aso_out0_ready          in   downstream ready
//   aso_out0_startofpacket  out  first byte of packet
//   aso_out0_endofpacket    out  last byte of packet
//   aso_out0_channel        out  granted requester index
//   busy                    out  grant held
// -----------------------------------------------------------------------------
module fixlen_byte_arbiter
    import fixlen_pkg::*;
#(
    parameter int  N_CH              = 4,
    parameter int  SYMBOL_PER_PACKET = 4,
    parameter int  BYTES_PER_SYMBOL  = 4,
    parameter int  BITS_PER_BYTES    = 8,
    localparam int CH_W              = ch_width(N_CH)
) (
    input  logic                           clock_clk,
    input  logic                           reset_reset,
    input  logic [N_CH*BITS_PER_BYTES-1:0] asi_in_data,
    input  logic [N_CH-1:0]                asi_in_valid,
    output logic [N_CH-1:0]                asi_in_ready,
    output logic [BITS_PER_BYTES-1:0]      aso_out0_data,
    output logic                           aso_out0_valid,
    input  logic                           aso_out0_ready,
    output logic                           aso_out0_startofpacket,
    output logic                           aso_out0_endofpacket,
    output logic [CH_W-1:0]                aso_out0_channel,
    output logic                           busy
);

    localparam int               BPP      = bytes_per_packet(SYMBOL_PER_PACKET, BYTES_PER_SYMBOL);
    localparam int               CNT_W    = cnt_width(BPP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPP - 1);
    // Reset 'last' to the top channel so the first search begins at channel 0.
    localparam logic [CH_W-1:0]  LAST_RST = CH_W'(N_CH - 1);

    state_t           state, state_nxt;
    logic [CH_W-1:0]  g, g_nxt;
    logic [CH_W-1:0]  last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pick_found;
    logic [CH_W-1:0]  pick_idx;
    logic             xfer;

    rr_picker #(
        .N_CH  (N_CH),
        .IDX_W (CH_W)
    ) u_picker (
        .req   (asi_in_valid),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state <= IDLE;
            g     <= '0;
            last  <= LAST_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Forward path: zero-latency mux of the granted stream; everyone else stalls.
    always_comb begin
        aso_out0_data  = '0;
        aso_out0_valid = 1'b0;
        asi_in_ready   = '0;
        if (state == BURST) begin
            for (int i = 0; i < N_CH; i++) begin
                if (g == CH_W'(i)) begin
                    aso_out0_data   = asi_in_data[i*BITS_PER_BYTES +: BITS_PER_BYTES];
                    aso_out0_valid  = asi_in_valid[i];
                    asi_in_ready[i] = aso_out0_ready;
                end
            end
        end
    end

    assign xfer = aso_out0_valid & aso_out0_ready;

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = BURST;
                    g_nxt     = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            BURST: begin
                // Bubbles from the granted requester simply freeze the count.
                if (xfer) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        last_nxt  = g;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy                   = (state == BURST);
    assign aso_out0_startofpacket = busy && (cnt == '0);
    assign aso_out0_endofpacket   = busy && (cnt == CNT_LAST);
    assign aso_out0_channel       = g;

endmodule

// File: doc/fixlen_byte_arbiter.md
# fixlen_byte_arbiter

Round-robin scheduler that shares one fixed-length byte-to-packet assembler among N_CH byte-stream requesters. It grants one requester at a time for exactly one packet's worth of bytes (SYMBOL_PER_PACKET × BYTES_PER_SYMBOL). It forwards those bytes on a single Avalon-ST source with packet markers and a channel tag. It sits directly upstream of the fixed-length packet assembler, so packets from different sources are never interleaved.

## Interface

Parameters:
- N_CH, 4, number of requesting byte streams (≥1)
- SYMBOL_PER_PACKET, 4, symbols per packet (≥1)
- BYTES_PER_SYMBOL, 4, bytes per symbol (≥1)
- BITS_PER_BYTES, 8, byte width

Ports:
- clock_clk  in  1  clock
- reset_reset  in  1  reset, asynchronous, active-high
- asi_in_data  in  N_CH×BITS_PER_BYTES  requester bytes; channel i occupies slice [i×BITS_PER_BYTES +: BITS_PER_BYTES]
- asi_in_valid  in  N_CH  per-requester valid
- asi_in_ready  out  N_CH  per-requester ready
- aso_out0_data  out  BITS_PER_BYTES  granted byte
- aso_out0_valid  out  1  granted byte valid
- aso_out0_ready  in  1  downstream ready
- aso_out0_startofpacket  out  1  first byte of packet
- aso_out0_endofpacket  out  1  last byte of packet
- aso_out0_channel  out  CH_W  granted requester index
- busy  out  1  grant held (state BURST)

## Operation

- BYTES_PER_PACKET = SYMBOL_PER_PACKET × BYTES_PER_SYMBOL.
- CH_W = max(1, clog2(N_CH)).
- Byte counter width = max(1, clog2(BYTES_PER_PACKET)).
- A transfer is a cycle in which aso_out0_valid and aso_out0_ready are both high.
- States:
  - IDLE: no grant.
  - BURST: grant register g is held.
- IDLE → BURST when any asi_in_valid bit is high.
  - g becomes the first asserted channel searched from (last+1) mod N_CH, wrapping.
  - Byte counter clears to 0.
- BURST → IDLE on the transfer with counter = BYTES_PER_PACKET−1.
  - last updates to g.
- In BURST:
  - Otherwise each transfer increments the counter.
- Datapath is combinational in BURST:
  - aso_out0_data = slice g
  - aso_out0_valid = asi_in_valid[g]
  - asi_in_ready[g] = aso_out0_ready
  - all other ready bits are 0
- In IDLE, aso_out0_valid = 0 and all asi_in_ready bits = 0.
- aso_out0_startofpacket = BURST & counter = 0.
- aso_out0_endofpacket = BURST & counter = BYTES_PER_PACKET−1.
  - For BYTES_PER_PACKET = 1, both markers are high on the same byte.
- aso_out0_channel = g, held stable throughout BURST.
- Requester bubbles (valid low while granted) do not release the grant. The packet waits.
- Valid on non-granted channels is ignored. Those requesters are stalled by ready = 0.
- Reset is asynchronous:
  - state = IDLE, g = 0, last = N_CH−1 (so first search starts at channel 0), counter = 0.
  - All outputs therefore read 0.
  - Reset mid-BURST truncates the packet with no endofpacket. Recovery is the downstream's responsibility.

## Timing

- Arbitration latency: 1 cycle. Request seen in IDLE at cycle t → first byte presentable at t+1.
- One mandatory IDLE bubble after each endofpacket transfer. Maximum throughput is BYTES_PER_PACKET / (BYTES_PER_PACKET+1).
- Zero-latency forward path valid/data/ready in BURST. No registered output stage.
- Fairness: with all N_CH requesting continuously, each channel is granted exactly once per N_CH packets.

## Configuration

- FIXLEN_ARB_STRICT_PRIO_EN:
  - Defined: strict priority. The lowest-index asserted channel always wins, and the last pointer is unused.
  - Undefined: round-robin as above.
- Either way, a grant is never preempted mid-packet.

## Structure

- Shared package fixlen_pkg:
  - state enum {IDLE, BURST}
  - CH_W and counter-width helper functions (max(1, clog2(x)))
  - BYTES_PER_PACKET computation function
- One sub-module, rr_picker:
  - Combinational round-robin search over an N_CH-bit request vector from a start index.
  - Outputs found flag and index.
  - Also implements strict-priority mode when FIXLEN_ARB_STRICT_PRIO_EN is defined.

## Test plan

Configuration for all scenarios: N_CH=4, SYMBOL_PER_PACKET=2, BYTES_PER_SYMBOL=4 (8 bytes/packet), BITS_PER_BYTES=8.

1. Reset, channel 2 streams bytes 0x10..0x17 with ready=1 → first byte one cycle after valid; channel=2; SOP on 0x10, EOP on 0x17; busy falls the cycle after EOP.
2. Channels 0–3 all valid continuously → grant order 0,1,2,3,0. Each packet is 8 contiguous transfers followed by one idle cycle. A non-granted ready bit is never high.
3. Channel 1 granted, drops valid for 3 cycles after byte 3 → grant held, counter frozen at 4, remaining bytes follow, EOP on the 8th transfer.
4. aso_out0_ready toggles 1,0,1,0 during a packet → no byte duplicated or lost; exactly 8 transfers; SOP and EOP each asserted on exactly one transfer.
5. Assert reset after 5 bytes of channel 3 → all outputs 0 immediately. Next request from channel 3 starts at counter 0 with SOP, and round-robin restarts from channel 0.
6. With FIXLEN_ARB_STRICT_PRIO_EN defined, channels 0 and 3 both continuously valid → channel 0 wins every packet and channel 3 is never granted.
